pmem_server: RTL

//  Synthesizable program-memory responder for the 8-bit core: serves INSTR for the core's PC.

---
 rtl/pmem_server_if.sv | 31 +++
 rtl/pmem_server.sv | 89 ++++++++
 2 files changed

// File: rtl/pmem_server_if.sv
// pmem_server_if: loader, paging, control and core-facing signals of the program-memory server
interface pmem_server_if #(
  parameter int PC_LEN    = 4,
  parameter int INSTR_LEN = 8,
  parameter int NUM_PAGES = 4
);
  localparam int PG_W = NUM_PAGES > 1 ? $clog2(NUM_PAGES) : 1;
  logic                 start;
  logic [31:0]          max_cycles;
  logic                 ld_valid;
  logic                 ld_ready;
  logic [PG_W-1:0]      ld_page;
  logic [PC_LEN-1:0]    ld_addr;
  logic [INSTR_LEN-1:0] ld_data;
  logic                 page_we;
  logic [PG_W-1:0]      page_in;
  logic [PC_LEN-1:0]    PC;
  logic [INSTR_LEN-1:0] INSTR;
  logic                 core_rstn;
  logic                 halted;
  logic                 timed_out;
  logic [31:0]          cycle_count;
  modport master (
    output start, max_cycles, ld_valid, ld_page, ld_addr, ld_data, page_we, page_in, PC,
    input  ld_ready, INSTR, core_rstn, halted, timed_out, cycle_count
  );
  modport slave (
    input  start, max_cycles, ld_valid, ld_page, ld_addr, ld_data, page_we, page_in, PC,
    output ld_ready, INSTR, core_rstn, halted, timed_out, cycle_count
  );
endinterface

// File: rtl/pmem_server.sv
// pmem_server: paged program memory serving INSTR to the core, with reset/run sequencing and halt/time-out detection
module pmem_server #(
  parameter int PC_LEN     = 4,
  parameter int INSTR_LEN  = 8,
  parameter int NUM_PAGES  = 4,
  parameter int RST_CYCLES = 4
) (
  input  logic CLK,
  input  logic RSTN,
  pmem_server_if.slave bus
);
  localparam int PG_W  = NUM_PAGES > 1 ? $clog2(NUM_PAGES) : 1;
  localparam int WORDS = 1 << PC_LEN;
  localparam int RCW   = $clog2(RST_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, RST_HOLD, RUN, HALT, TIMEOUT} state_t;
  state_t               state, state_nx;
  logic [INSTR_LEN-1:0] mem [NUM_PAGES][WORDS];
  logic [PG_W-1:0]      page;
  logic [RCW-1:0]       rst_cnt;
  logic [31:0]          max_r, cnt;
  logic [PC_LEN-1:0]    last_pc;
  logic                 pc_valid, halted_r, tout_r;
  logic [INSTR_LEN-1:0] instr_r;
  logic                 ld_rdy, core_on, halt_hit, tout_hit, start_ok;
  assign halt_hit = pc_valid && bus.PC == last_pc;
  assign tout_hit = max_r != 32'd0 && cnt + 32'd1 == max_r;
  assign start_ok = ld_rdy && bus.start;
  // State register; reset aborts any run straight back to IDLE
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) state <= IDLE;
    else state <= state_nx;
  // Next state: a start is only honoured outside RST_HOLD/RUN; halt beats time-out
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, HALT, TIMEOUT: state_nx = bus.start ? RST_HOLD : state;
      RST_HOLD: state_nx = rst_cnt == RCW'(RST_CYCLES - 1) ? RUN : RST_HOLD;
      RUN: state_nx = halt_hit ? HALT : tout_hit ? TIMEOUT : RUN;
      default: state_nx = IDLE;
    endcase
  end
  // Outputs decoded from the registered state; the core stays released while halted or timed out
  always_comb begin
    ld_rdy  = state == IDLE || state == HALT || state == TIMEOUT;
    core_on = state == RUN || state == HALT || state == TIMEOUT;
  end
  // Run bookkeeping: reset-hold counter, sampled time-out, cycle count, halt-loop tracking, page register
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      rst_cnt  <= '0;
      max_r    <= '0;
      cnt      <= '0;
      last_pc  <= '0;
      pc_valid <= 1'b0;
      halted_r <= 1'b0;
      tout_r   <= 1'b0;
      page     <= '0;
    end else begin
      if (start_ok) begin
        rst_cnt  <= '0;
        max_r    <= bus.max_cycles;
        cnt      <= '0;
        pc_valid <= 1'b0;
        halted_r <= 1'b0;
        tout_r   <= 1'b0;
      end else if (state == RST_HOLD) rst_cnt <= rst_cnt + 1'b1;
      else if (state == RUN) begin
        cnt      <= &cnt ? cnt : cnt + 32'd1;
        last_pc  <= bus.PC;
        pc_valid <= 1'b1;
        halted_r <= halt_hit;
        tout_r   <= tout_hit && !halt_hit;
      end
      if (bus.page_we && 32'(bus.page_in) < NUM_PAGES) page <= bus.page_in;
    end
  // Loader writes; contents survive reset and out-of-range pages are dropped
  always_ff @(posedge CLK)
    if (bus.ld_valid && ld_rdy && 32'(bus.ld_page) < NUM_PAGES) mem[bus.ld_page][bus.ld_addr] <= bus.ld_data;
  // Negedge fetch gives the core its instruction half a cycle after PC moves
  always_ff @(negedge CLK or negedge RSTN)
    if (!RSTN) instr_r <= '0;
    else instr_r <= core_on ? mem[page][bus.PC] : '0;
  assign bus.ld_ready    = ld_rdy;
  assign bus.core_rstn   = core_on;
  assign bus.INSTR       = instr_r;
  assign bus.halted      = halted_r;
  assign bus.timed_out   = tout_r;
  assign bus.cycle_count = cnt;
endmodule
